// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: element word field positions, FSM state encoding
// and small elaboration-time helpers.
package vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } vstate_e;

  // Field positions inside an element word of a given result width.
  function automatic int elem_valid_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int elem_mask_bit(input int dw);
    return dw;
  endfunction

  function automatic int vec_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bits needed to hold the value n itself (0..n).
  function automatic int vec_bits(input int n);
    return (n < 1) ? 1 : vec_clog2(n + 1);
  endfunction

endpackage

// File: rtl/vcmp_mask_collector.sv
// Collects bit 0 of each active compare result into an MVL-bit destination mask
// and hands the finished mask to the mask-register write port.
module vcmp_mask_collector
  import vec_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int MVL        = 16,
  parameter  int REG_W      = 5,
  localparam int VL_W       = vec_bits(MVL)
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic                  masked_i,
  input  logic [REG_W-1:0]      dst_i,
  input  logic [MVL-1:0]        dst_old_i,
  input  logic [DATA_WIDTH+1:0] elem_i,
  output logic [MVL-1:0]        mask_o,
  output logic [REG_W-1:0]      wr_addr_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int VBIT = elem_valid_bit(DATA_WIDTH);
  localparam int MBIT = elem_mask_bit(DATA_WIDTH);

  vstate_e         state;
  logic [VL_W-1:0] idx;
  logic [VL_W-1:0] vl_q;
  logic [MVL-1:0]  mask_upd;

  logic elem_vld, elem_msk, elem_res, elem_act, last_elem;
  logic unused_res_hi;

  assign elem_vld  = elem_i[VBIT];
  assign elem_msk  = elem_i[MBIT];
  assign elem_res  = elem_i[0];
  assign elem_act  = !masked_i || elem_msk;
  assign last_elem = (idx == vl_q - VL_W'(1));

  // Only the LSB of the compare result carries the predicate.
  assign unused_res_hi = ^elem_i[DATA_WIDTH-1:1];

  // Decoded single-bit write into the mask at the current element index.
  always_comb begin
    mask_upd = mask_o;
    for (int i = 0; i < MVL; i++) begin
      if (idx == VL_W'(i)) mask_upd[i] = elem_res;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask_o     <= '0;
      wr_addr_o  <= '0;
      idx        <= '0;
      vl_q       <= '0;
      wr_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            vl_q      <= vl_i;
            wr_addr_o <= dst_i;
            mask_o    <= dst_old_i;
            idx       <= '0;
            ovf_o     <= 1'b0;
            busy_o    <= 1'b1;
            if (vl_i == '0) begin
              state      <= ST_WRITE;
              wr_valid_o <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end else if (elem_vld) begin
            ovf_o <= 1'b1;
          end
        end

        ST_COLLECT: begin
          if (elem_vld) begin
            if (elem_act) mask_o <= mask_upd;
            idx <= idx + VL_W'(1);
            if (last_elem) begin
              state      <= ST_WRITE;
              wr_valid_o <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (elem_vld) ovf_o <= 1'b1;
          if (wr_ready_i) begin
            state      <= ST_IDLE;
            wr_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          wr_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule
